// File: rtl/clk_div_pkg.sv
// clk_div_pkg: LCD panel IDs, pixel-ratio codes and the ID-to-ratio decoder shared by clk_div_multi.
package clk_div_pkg;
  localparam logic [15:0] ID_4342 = 16'h4342;
  localparam logic [15:0] ID_7084 = 16'h7084;
  localparam logic [15:0] ID_7016 = 16'h7016;
  localparam logic [15:0] ID_4384 = 16'h4384;
  localparam logic [15:0] ID_1018 = 16'h1018;
  typedef enum logic [1:0] {DIV1 = 2'd0, DIV2 = 2'd1, DIV4 = 2'd2, DIV_OFF = 2'd3} lcd_div_e;
  function automatic lcd_div_e lcd_ratio(input logic [15:0] id);
    return id == ID_4342 ? DIV4 :
           (id == ID_7084 || id == ID_4384) ? DIV2 :
           (id == ID_7016 || id == ID_1018) ? DIV1 : DIV_OFF;
  endfunction
endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one runtime-programmable 50%-duty divider with rising-edge tick; new half-periods
// take effect only at a wrap (or immediately when halted), so running periods never glitch.
module clk_div_chan #(
  parameter int CNT_W = 22,
  parameter logic [CNT_W-1:0] INIT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [CNT_W-1:0] val,
  input  logic             align,
  output logic             clk_out,
  output logic             tick
);
  logic [CNT_W-1:0] r_cnt, r_active, r_pending, w_pend_nx;
  logic r_clk, r_tick, w_run, w_wrap, w_stop;
  always_comb begin
    w_pend_nx = we ? val : r_pending;
    w_run     = r_active != '0;
    w_wrap    = w_run && r_cnt == r_active - CNT_W'(1);
    w_stop    = w_pend_nx == '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_active  <= INIT;
      r_pending <= INIT;
      r_clk     <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_pending <= w_pend_nx;
      if (align || !w_run) begin
        r_cnt    <= '0;
        r_clk    <= 1'b0;
        r_tick   <= 1'b0;
        r_active <= w_pend_nx;
      end else if (w_wrap) begin
        // a zero divisor lands here: finish the half-period, then park low instead of toggling
        r_cnt    <= '0;
        r_active <= w_pend_nx;
        r_clk    <= !w_stop && !r_clk;
        r_tick   <= !w_stop && !r_clk;
      end else begin
        r_cnt  <= r_cnt + CNT_W'(1);
        r_tick <= 1'b0;
      end
    end
  end
  assign clk_out = r_clk;
  assign tick    = r_tick;
endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: CH programmable clock-enable dividers plus lcd_id-driven pixel-clock prescaler.
// Defining CLK_DIV_ALIGN_EN adds an `align` input that restarts all channels and the prescaler in phase.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int CH = 4,
  parameter int CNT_W = 22,
  parameter logic [CH*CNT_W-1:0] DIV_INIT = '0,
  localparam int SEL_W = $clog2(CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      lcd_id,
  input  logic             div_we,
  input  logic [SEL_W-1:0] div_sel,
  input  logic [CNT_W-1:0] div_val,
`ifdef CLK_DIV_ALIGN_EN
  input  logic             align,
`endif
  output logic [CH-1:0]    clk_out,
  output logic [CH-1:0]    tick,
  output logic             lcd_pclk_en,
  output logic [1:0]       lcd_div
);
  logic w_align;
`ifdef CLK_DIV_ALIGN_EN
  assign w_align = align;
`else
  assign w_align = 1'b0;
`endif
  for (genvar i = 0; i < CH; i++) begin : g_ch
    clk_div_chan #(.CNT_W(CNT_W), .INIT(DIV_INIT[i*CNT_W +: CNT_W])) u_chan (
      .clk     (clk),
      .rst     (rst),
      .we      (div_we && div_sel == SEL_W'(i)),
      .val     (div_val),
      .align   (w_align),
      .clk_out (clk_out[i]),
      .tick    (tick[i])
    );
  end
  lcd_div_e w_ratio, r_lcd_div;
  logic [15:0] r_lcd_id;
  logic [1:0] r_psc, w_lim;
  logic w_chg, r_hold;
  always_comb begin
    w_ratio = lcd_ratio(lcd_id);
    w_chg   = lcd_id != r_lcd_id || w_ratio != r_lcd_div || w_align;
    w_lim   = r_lcd_div == DIV4 ? 2'd3 : r_lcd_div == DIV2 ? 2'd1 : 2'd0;
  end
  // r_hold blanks the enable for the one cycle in which a new ratio becomes visible
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lcd_div <= DIV_OFF;
      r_lcd_id  <= '0;
      r_psc     <= '0;
      r_hold    <= 1'b0;
    end else begin
      r_lcd_div <= w_ratio;
      r_lcd_id  <= lcd_id;
      r_hold    <= w_chg;
      r_psc     <= (w_chg || r_psc == w_lim) ? 2'd0 : r_psc + 2'd1;
    end
  end
  assign lcd_div     = r_lcd_div;
  assign lcd_pclk_en = !r_hold && (r_lcd_div == DIV1 || (r_lcd_div != DIV_OFF && r_psc == w_lim));
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: directed and randomized checks of clk_div_multi against a behavioural model.
module tb_clk_div_multi;
  import clk_div_pkg::*;
  localparam int CH = 3;
  localparam int CNT_W = 8;
  localparam logic [CH*CNT_W-1:0] DIV_INIT = {8'd0, 8'd0, 8'd3};
  localparam int INIT [CH] = '{3, 0, 0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] lcd_id = 16'h0000;
  logic div_we = 1'b0;
  logic [1:0] div_sel = 2'd0;
  logic [CNT_W-1:0] div_val = '0;
  logic al = 1'b0;
  logic [CH-1:0] clk_out, tick;
  logic lcd_pclk_en;
  logic [1:0] lcd_div;

  clk_div_multi #(.CH(CH), .CNT_W(CNT_W), .DIV_INIT(DIV_INIT)) dut (
    .clk         (clk),
    .rst         (rst),
    .lcd_id      (lcd_id),
    .div_we      (div_we),
    .div_sel     (div_sel),
    .div_val     (div_val),
`ifdef CLK_DIV_ALIGN_EN
    .align       (al),
`endif
    .clk_out     (clk_out),
    .tick        (tick),
    .lcd_pclk_en (lcd_pclk_en),
    .lcd_div     (lcd_div)
  );

  always #5 clk = ~clk;

  int n_tot = 0;
  int n_pass = 0;

  // model: each channel counts down the cycles left in its current half-period
  int m_act [CH];
  int m_pend [CH];
  int m_left [CH];
  bit m_lvl [CH];
  bit m_tk [CH];
  int m_div = 3;
  int m_since = 0;
  logic [15:0] m_prev = 16'h0000;

  function automatic int ref_ratio(input logic [15:0] id);
    case (id)
      16'h4342:           return 2;
      16'h7084, 16'h4384: return 1;
      16'h7016, 16'h1018: return 0;
      default:            return 3;
    endcase
  endfunction

  function automatic bit ref_en();
    case (m_div)
      0:       return m_since != 0;
      1:       return m_since % 2 == 1;
      2:       return m_since % 4 == 3;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_step();
    int r;
    for (int c = 0; c < CH; c++) begin
      int pn;
      pn = (div_we && int'(div_sel) == c) ? int'(div_val) : m_pend[c];
      if (rst) begin
        m_act[c] = INIT[c]; m_pend[c] = INIT[c]; m_left[c] = INIT[c];
        m_lvl[c] = 1'b0; m_tk[c] = 1'b0;
      end else begin
        m_tk[c] = 1'b0;
        if (al || m_act[c] == 0) begin
          m_act[c] = pn; m_left[c] = pn; m_lvl[c] = 1'b0;
        end else begin
          m_left[c] = m_left[c] - 1;
          if (m_left[c] == 0) begin
            m_act[c] = pn; m_left[c] = pn;
            if (pn == 0) m_lvl[c] = 1'b0;
            else begin
              m_tk[c] = !m_lvl[c];
              m_lvl[c] = !m_lvl[c];
            end
          end
        end
        m_pend[c] = pn;
      end
    end
    if (rst) begin
      m_div = 3; m_since = 0; m_prev = 16'h0000;
    end else begin
      r = ref_ratio(lcd_id);
      if (lcd_id != m_prev || r != m_div || al) m_since = 0;
      else m_since++;
      m_div = r;
      m_prev = lcd_id;
    end
  endtask

  task automatic cyc();
    logic [CH-1:0] ec, et;
    @(posedge clk);
    model_step();
    #1;
    for (int c = 0; c < CH; c++) begin
      ec[c] = m_lvl[c];
      et[c] = m_tk[c];
    end
    chk("clk_out", 32'(clk_out), 32'(ec));
    chk("tick", 32'(tick), 32'(et));
    chk("lcd_div", 32'(lcd_div), 32'(m_div));
    chk("lcd_pclk_en", 32'(lcd_pclk_en), 32'(ref_en()));
  endtask

  task automatic write(input int sel, input int val);
    div_we = 1'b1; div_sel = 2'(sel); div_val = CNT_W'(val);
    cyc();
    div_we = 1'b0;
  endtask

  logic [15:0] ids [6] = '{ID_4342, ID_7084, ID_7016, ID_4384, ID_1018, 16'h0000};
  int cnt, first0, first1;

  initial begin
    for (int c = 0; c < CH; c++) begin
      m_act[c] = INIT[c]; m_pend[c] = INIT[c]; m_left[c] = INIT[c];
      m_lvl[c] = 1'b0; m_tk[c] = 1'b0;
    end
    repeat (3) cyc();
    chk("rst_clk_out", 32'(clk_out), 0);
    chk("rst_lcd_div", 32'(lcd_div), 3);
    chk("rst_en", 32'(lcd_pclk_en), 0);
    rst = 1'b0;
    // ch0 period 6, ch1 halted
    cnt = 0; first1 = 0;
    for (int k = 0; k < 12; k++) begin
      cyc();
      cnt += int'(tick[0]);
      first1 += int'(clk_out[1]);
    end
    chk("t1_ticks_ch0", 32'(cnt), 2);
    chk("t1_ch1_idle", 32'(first1), 0);
    // retime ch0 mid half-period, then on an exact wrap
    cyc();
    write(0, 5);
    repeat (25) cyc();
    for (int k = 0; k < 12 && m_left[0] != 1; k++) cyc();
    chk("t2_at_wrap", 32'(m_left[0]), 1);
    write(0, 2);
    repeat (10) cyc();
    // ch2: start, stop with 0, restart
    write(2, 4);
    repeat (11) cyc();
    write(2, 0);
    repeat (10) cyc();
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      cnt += int'(tick[2]) + int'(clk_out[2]);
    end
    chk("t3_halted", 32'(cnt), 0);
    write(2, 2);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      cnt += int'(tick[2]);
    end
    chk("t3_restart_ticks", 32'(cnt), 2);
    // pixel prescaler
    lcd_id = ID_4342;
    cyc();
    chk("t4_div4", 32'(lcd_div), 2);
    chk("t4_blank", 32'(lcd_pclk_en), 0);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      cnt += int'(lcd_pclk_en);
    end
    chk("t4_div4_strobes", 32'(cnt), 2);
    lcd_id = ID_7016;
    cyc();
    chk("t4_div1_blank", 32'(lcd_pclk_en), 0);
    cyc();
    chk("t4_div1_on", 32'(lcd_pclk_en), 1);
    lcd_id = 16'h0000;
    cyc();
    chk("t4_off_div", 32'(lcd_div), 3);
    cyc();
    chk("t4_off_en", 32'(lcd_pclk_en), 0);
    // out-of-range select and mid-run reset
    lcd_id = ID_7084;
    write(3, 7);
    repeat (5) cyc();
    rst = 1'b1;
    cyc();
    chk("t5_rst_clk", 32'(clk_out), 0);
    chk("t5_rst_tick", 32'(tick), 0);
    chk("t5_rst_div", 32'(lcd_div), 3);
    rst = 1'b0;
    repeat (4) cyc();
`ifdef CLK_DIV_ALIGN_EN
    write(0, 3);
    write(1, 5);
    repeat (13) cyc();
    al = 1'b1;
    cyc();
    al = 1'b0;
    chk("t6_align_clk", 32'(clk_out[1:0]), 0);
    first0 = 0; first1 = 0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (first0 == 0 && clk_out[0]) first0 = k;
      if (first1 == 0 && clk_out[1]) first1 = k;
    end
    chk("t6_first_ch0", 32'(first0), 3);
    chk("t6_first_ch1", 32'(first1), 5);
`endif
    // randomized traffic
    for (int k = 0; k < 800; k++) begin
      div_we  = 1'($urandom_range(0, 1));
      div_sel = 2'($urandom_range(0, 3));
      div_val = CNT_W'($urandom_range(0, 6));
      if ($urandom_range(0, 15) == 0) lcd_id = ids[$urandom_range(0, 5)];
      rst = $urandom_range(0, 149) == 0;
`ifdef CLK_DIV_ALIGN_EN
      al = $urandom_range(0, 59) == 0;
`endif
      cyc();
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
